// File: rtl/fetch_unit.sv
// Fetch stage for the 9-bit stack machine: owns the PC, samples the
// combinational ROM output into a fetch register, and handles
// run/halt control, decode stalls, branch redirects and halt detection.
module fetch_unit #(
    parameter int unsigned           PC_W    = 8,
    parameter int unsigned           INST_W  = 9,
    parameter logic [INST_W-1:0]     HALT_OP = INST_W'(9'h1FF),
    parameter int unsigned           CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   branch_target,
    input  logic [INST_W-1:0] inst_in,
    output logic [PC_W-1:0]   PC,
    output logic [INST_W-1:0] inst_out,
    output logic              inst_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  run_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [INST_W-1:0]   r_inst;
    logic                r_valid;
    logic                r_halted;
    logic [CNT_W-1:0]    r_cnt;

    state_t              w_state_nxt;
    logic [PC_W-1:0]     w_pc_nxt;
    logic [INST_W-1:0]   w_inst_nxt;
    logic                w_valid_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_is_halt_op;

    // Saturating run-cycle increment and halt-opcode decode of the ROM word.
    always_comb begin
        w_cnt_inc    = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
        w_is_halt_op = (inst_in == HALT_OP);
    end

    // Next-state and next-register values; redirect beats stall beats halt.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_valid_nxt = r_valid;
        w_cnt_nxt   = r_cnt;

        unique case (r_state)
            ST_IDLE: begin
                w_pc_nxt    = '0;
                w_valid_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            end

            ST_RUN: begin
                w_cnt_nxt = w_cnt_inc;
                if (redirect) begin
                    // Flush the wrong-path fetch; keep the last good word.
                    w_pc_nxt    = branch_target;
                    w_valid_nxt = 1'b0;
                end else if (stall) begin
                    w_pc_nxt    = r_pc;
                end else if (w_is_halt_op) begin
                    // Hand the halt word to decode, park the PC on it.
                    w_inst_nxt  = HALT_OP;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_HALT;
                end else begin
                    w_inst_nxt  = inst_in;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = r_pc + PC_W'(1);
                end
            end

            ST_HALT: begin
                w_valid_nxt = 1'b0;
                if (start) begin
                    w_pc_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = '0;
                w_valid_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and fetch registers; synchronous reset wins over everything.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_inst   <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_inst   <= w_inst_nxt;
            r_valid  <= w_valid_nxt;
            r_halted <= (w_state_nxt == ST_HALT);
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Output drive straight from the registers.
    always_comb begin
        PC         = r_pc;
        inst_out   = r_inst;
        inst_valid = r_valid;
        halted     = r_halted;
        run_cycles = r_cnt;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a random
// run, all compared against a cycle-level behavioural model.
module tb_fetch_unit;

    localparam int unsigned PC_W   = 8;
    localparam int unsigned INST_W = 9;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned VEC_W  = PC_W + INST_W + 1 + 1 + CNT_W;

    logic              CLK = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stall = 1'b0;
    logic              redirect = 1'b0;
    logic [PC_W-1:0]   branch_target = '0;
    logic [INST_W-1:0] inst_in;
    logic [PC_W-1:0]   PC;
    logic [INST_W-1:0] inst_out;
    logic              inst_valid;
    logic              halted;
    logic [CNT_W-1:0]  run_cycles;

    logic [INST_W-1:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: mode 0 idle, 1 running, 2 halted.
    int                m_mode  = 0;
    int                m_pc    = 0;
    int                m_out   = 0;
    int                m_valid = 0;
    int                m_cnt   = 0;

    always #5 CLK = ~CLK;

    assign inst_in = mem[PC];

    fetch_unit #(
        .PC_W    (PC_W),
        .INST_W  (INST_W),
        .HALT_OP (9'h1FF),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .redirect      (redirect),
        .branch_target (branch_target),
        .inst_in       (inst_in),
        .PC            (PC),
        .inst_out      (inst_out),
        .inst_valid    (inst_valid),
        .halted        (halted),
        .run_cycles    (run_cycles)
    );

    function automatic logic [VEC_W-1:0] obs_vec();
        return {PC, inst_out, inst_valid, halted, run_cycles};
    endfunction

    function automatic logic [VEC_W-1:0] mdl_vec();
        return {PC_W'(m_pc), INST_W'(m_out), 1'(m_valid), 1'(m_mode == 2), CNT_W'(m_cnt)};
    endfunction

    // Drive one cycle of inputs, advance the model, and settle after the edge.
    task automatic step(input logic rst, input logic st, input logic stl,
                        input logic rd, input logic [PC_W-1:0] tgt);
        int rom;
        reset = rst; start = st; stall = stl; redirect = rd; branch_target = tgt;
        rom = int'(mem[m_pc]);
        if (rst) begin
            m_mode = 0; m_pc = 0; m_out = 0; m_valid = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_pc = 0; m_valid = 0;
            if (st) begin m_mode = 1; m_cnt = 0; end
        end else if (m_mode == 1) begin
            if (m_cnt < 15) m_cnt = m_cnt + 1;
            if (rd) begin
                m_pc = int'(tgt); m_valid = 0;
            end else if (stl) begin
                m_pc = m_pc;
            end else if (rom == 'h1FF) begin
                m_out = rom; m_valid = 1; m_mode = 2;
            end else begin
                m_out = rom; m_valid = 1; m_pc = (m_pc + 1) % 256;
            end
        end else begin
            m_valid = 0;
            if (st) begin m_pc = 0; m_cnt = 0; m_mode = 1; end
        end
        @(posedge CLK);
        #1;
        reset = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 8'h55);
        n_tests++;
        if (obs_vec() !== VEC_W'(0)) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), VEC_W'(0));
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 256; i++) mem[i] = INST_W'($urandom_range(0, 'h1FE));
        for (int i = 0; i < 'h30; i++) mem[i] = INST_W'(i);
        mem[24]   = 9'h1FF;
        mem[8'hFF] = 9'h0AB;
        step(0, 1, 0, 0, 0);
        n_tests++;
        if (PC !== 8'h00 || inst_valid !== 1'b0 || run_cycles !== 4'd0) begin
            n_fail++;
            $display("FAIL seq_start: pc=%h valid=%b cnt=%0d expected pc=00 valid=0 cnt=0",
                     PC, inst_valid, run_cycles);
        end
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0, 0);
            n_tests++;
            if (PC !== PC_W'(k) || inst_out !== INST_W'(k - 1) || inst_valid !== 1'b1 ||
                run_cycles !== CNT_W'(k) || obs_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL seq_fetch%0d: got %h expected %h", k, obs_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 1, 0, 0);
            n_tests++;
            if (PC !== 8'h03 || inst_out !== 9'h002 || inst_valid !== 1'b1 ||
                obs_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got %h expected %h", k, obs_vec(), mdl_vec());
            end
        end
        step(0, 0, 0, 0, 0);
        n_tests++;
        if (PC !== 8'h04 || inst_out !== 9'h003 || obs_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL stall_release: got %h expected %h", obs_vec(), mdl_vec());
        end
    endtask

    task automatic test_redirect();
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 8'h10);
        n_tests++;
        if (PC !== 8'h10 || inst_valid !== 1'b0 || inst_out !== 9'h004 ||
            obs_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL redirect_prio: got %h expected %h", obs_vec(), mdl_vec());
        end
        step(0, 0, 0, 0, 0);
        n_tests++;
        if (inst_out !== 9'h010 || inst_valid !== 1'b1 || PC !== 8'h11) begin
            n_fail++;
            $display("FAIL redirect_target: out=%h valid=%b pc=%h expected out=010 valid=1 pc=11",
                     inst_out, inst_valid, PC);
        end
    endtask

    task automatic test_halt();
        logic [CNT_W-1:0] frozen;
        for (int k = 0; k < 7; k++) step(0, 0, 0, 0, 0);
        n_tests++;
        if (PC !== 8'd24 || obs_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL halt_approach: got %h expected %h", obs_vec(), mdl_vec());
        end
        step(0, 0, 0, 0, 0);
        n_tests++;
        if (inst_out !== 9'h1FF || inst_valid !== 1'b1 || halted !== 1'b1 || PC !== 8'd24) begin
            n_fail++;
            $display("FAIL halt_fetch: out=%h valid=%b halted=%b pc=%h expected 1ff 1 1 18",
                     inst_out, inst_valid, halted, PC);
        end
        frozen = CNT_W'(m_cnt);
        step(0, 0, 1, 1, 8'h40);
        step(0, 0, 0, 0, 0);
        n_tests++;
        if (inst_valid !== 1'b0 || halted !== 1'b1 || PC !== 8'd24 || run_cycles !== frozen ||
            obs_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL halt_hold: got %h expected %h", obs_vec(), mdl_vec());
        end
        step(0, 1, 0, 0, 0);
        n_tests++;
        if (PC !== 8'h00 || halted !== 1'b0 || run_cycles !== 4'd0 || obs_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL halt_restart: got %h expected %h", obs_vec(), mdl_vec());
        end
    endtask

    task automatic test_wrap_saturate();
        step(0, 0, 0, 1, 8'hFF);
        n_tests++;
        if (PC !== 8'hFF || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_redirect: pc=%h valid=%b expected ff 0", PC, inst_valid);
        end
        step(0, 0, 0, 0, 0);
        n_tests++;
        if (PC !== 8'h00 || inst_out !== 9'h0AB || inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_pc: pc=%h out=%h valid=%b expected 00 0ab 1", PC, inst_out, inst_valid);
        end
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 0);
        n_tests++;
        if (run_cycles !== 4'hF || PC !== 8'd20 || obs_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL cnt_saturate: got %h expected %h", obs_vec(), mdl_vec());
        end
    endtask

    task automatic test_reset_dominance();
        step(1, 0, 1, 0, 0);
        n_tests++;
        if (obs_vec() !== VEC_W'(0)) begin
            n_fail++;
            $display("FAIL reset_midrun: got %h expected %h", obs_vec(), VEC_W'(0));
        end
        step(0, 0, 1, 1, 8'h33);
        n_tests++;
        if (PC !== 8'h00 || inst_valid !== 1'b0 || run_cycles !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_ignore: pc=%h valid=%b cnt=%0d expected 00 0 0", PC, inst_valid, run_cycles);
        end
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        n_tests++;
        if (obs_vec() !== VEC_W'(0)) begin
            n_fail++;
            $display("FAIL reset_with_start: got %h expected %h", obs_vec(), VEC_W'(0));
        end
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        n_tests++;
        if (PC !== 8'h01 || inst_out !== 9'h000 || inst_valid !== 1'b1 || run_cycles !== 4'd1) begin
            n_fail++;
            $display("FAIL restart_fetch: got %h expected %h", obs_vec(), mdl_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) begin
            mem[i] = INST_W'($urandom_range(0, 'h1FE));
            if ($urandom_range(0, 99) < 4) mem[i] = 9'h1FF;
        end
        for (int k = 0; k < 400; k++) begin
            logic rst, st, stl, rd;
            rst = ($urandom_range(0, 99) < 2);
            st  = ($urandom_range(0, 99) < ((m_mode == 1) ? 10 : 40));
            stl = ($urandom_range(0, 99) < 25);
            rd  = ($urandom_range(0, 99) < 10);
            step(rst, st, stl, rd, PC_W'($urandom_range(0, 255)));
            n_tests++;
            if (obs_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", k, obs_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap_saturate();
        test_reset_dominance();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch-stage block for the 9-bit stack machine.
- Drives the 8-bit PC into the combinational instruction ROM and samples the returned 9-bit instruction into a fetch register for the decode stage.
- Handles run/halt control, decode-stage stalls, branch redirects with flush, and halt-opcode detection.
- Sits between the control/decode logic (downstream) and the instruction ROM (upstream, combinational, same cycle).

Parameters:
- PC_W, 8, PC and branch-target width; PC wraps modulo 2^PC_W.
- INST_W, 9, instruction width.
- HALT_OP, 9'h1FF, opcode that terminates fetch.
- CNT_W, 16, run-cycle counter width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins or restarts fetching from PC 0.
- stall  in  1  decode stage cannot accept; hold fetch state.
- redirect  in  1  taken branch/jump; load branch_target.
- branch_target  in  PC_W  redirect destination.
- inst_in  in  INST_W  ROM output for the current PC (combinational).
- PC  out  PC_W  current fetch address, driven to the ROM.
- inst_out  out  INST_W  registered fetched instruction.
- inst_valid  out  1  inst_out holds a valid instruction this cycle.
- halted  out  1  halt opcode fetched; fetch stopped.
- run_cycles  out  CNT_W  cycles spent in RUN, including stalls.

Behaviour:
- States are IDLE, RUN and HALT; the state register is internal.
- Reset: state=IDLE, PC=0, inst_out=0, inst_valid=0, halted=0, run_cycles=0. Reset overrides every other input in the same cycle.
- IDLE:
  - PC held at 0 and inst_valid=0.
  - start moves to RUN and clears run_cycles.
  - redirect and stall are ignored.
- RUN, evaluated in priority order each cycle:
  1. redirect: PC<=branch_target, inst_valid<=0 (the wrong-path fetch is flushed), inst_out unchanged. Redirect wins over stall and over halt detection.
  2. stall: PC, inst_out and inst_valid all hold.
  3. inst_in==HALT_OP: inst_out<=HALT_OP, inst_valid<=1, PC holds, state<=HALT.
  4. Otherwise: inst_out<=inst_in, inst_valid<=1, PC<=PC+1. PC wraps from 2^PC_W-1 to 0.
- run_cycles increments on every RUN cycle and saturates at all-ones.
- start while in RUN is ignored.
- Latency: an instruction at PC=n appears on inst_out one cycle after PC=n is presented, provided that cycle is not stalled or redirected.
- HALT:
  - halted=1; PC holds the halt address; run_cycles is frozen.
  - inst_valid drops to 0 on the cycle after the halt instruction was presented.
  - redirect and stall are ignored.
  - start: PC<=0, halted<=0, run_cycles<=0, state<=RUN.
- halted is a registered output: it is 1 exactly when state=HALT.
- Reset mid-RUN or mid-HALT returns to the full reset state on the next edge. No partial instruction survives.

Test Plan:
- Sequential fetch: ROM holds 9'h000..9'h006 at 0..6. Apply reset, then start. Required: PC steps 0,1,2,…; inst_out=000,001,002,… one cycle behind PC; inst_valid=1 from the first fetch; run_cycles increments each cycle.
- Stall: assert stall for 2 cycles while PC=3. Required: PC stays 3, inst_out stays 9'h002, inst_valid stays 1. On release, inst_out=9'h003 and PC=4.
- Redirect priority: assert redirect with branch_target=8'h10 together with stall at PC=5. Required next cycle: PC=8'h10, inst_valid=0. The cycle after: inst_out=mem[0x10], inst_valid=1.
- Halt: ROM holds 9'h1FF at 24. Required: inst_out=9'h1FF with inst_valid=1 for one cycle, then halted=1, inst_valid=0, PC held at 24, run_cycles frozen. A start pulse then yields PC=0, halted=0, run_cycles=0.
- Wrap and saturation: redirect to 8'hFF with a non-halt opcode there. Required: PC goes 0xFF→0x00. Force run_cycles to 0xFFFE via a long run, or use CNT_W=4 with 15+ cycles. Required: the counter saturates and does not wrap.
- Reset dominance: assert reset together with start, and separately reset in mid-RUN with stall=1. Required: the next cycle shows state IDLE, PC=0, inst_valid=0, halted=0, run_cycles=0; no fetch occurs until a later start.
